// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sequences one load/store at a time between execute and a word-organised
//   data memory. Byte/halfword/word accesses become word-aligned memory cycles;
//   sub-word stores are read-modify-write. Load data is lane-extracted and
//   sign/zero-extended, then returned with a one-cycle Valid pulse.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned half/word requests complete at once with Error=1
//     undefined : Error tied low, unneeded low address bits ignored
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   Req/Ready         request handshake (accept on Req && Ready)
//   IsStore, Size, Unsigned, Addr, StData   request fields (latched on accept)
//   Valid, RdData, Error                    completion pulse and result
//   MemAddress, MemRead, MemWrite, MemWriteData, MemReadData   memory side
// -----------------------------------------------------------------------------

// One byte lane of the store merge: keep the old byte unless this lane is hit.
module lsu_byte_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] old_b,
  input  logic [LANE_W-1:0] new_b,
  input  logic              we,
  output logic [LANE_W-1:0] out_b
);
  assign out_b = we ? new_b : old_b;
endmodule

module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] StData,
  output logic        Ready,
  output logic        Valid,
  output logic [31:0] RdData,
  output logic        Error,
  output logic [31:0] MemAddress,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
  } lsu_req_t;

  state_t   state_q, state_d;
  lsu_req_t req_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misalign;

  assign Ready  = (state_q == IDLE);
  assign accept = Req && Ready;

`ifdef LSU_MISALIGN_TRAP_EN
  // Evaluated on the incoming request; only meaningful at acceptance.
  assign misalign = ((Size == 2'b01) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (misalign)                state_d = RESP;
        else if (IsStore && Size[1]) state_d = WR;   // full word: no read needed
        else                         state_d = RD;
      end
      RD:      state_d = req_q.st ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction / extension (from live memory data during RD)
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = MemReadData[{req_q.addr[1:0], 3'b000} +: 8];
    ld_half = req_q.addr[1] ? MemReadData[31:16] : MemReadData[15:0];
    case (req_q.size)
      2'b00:   ld_ext = {{24{~req_q.uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~req_q.uns & ld_half[15]}}, ld_half};
      default: ld_ext = MemReadData;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, old word, result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q   <= '{st: IsStore, size: Size, uns: Unsigned, addr: Addr, data: StData};
        rdata_q <= '0;
      end else if (state_q == RD) begin
        if (req_q.st) old_q   <= MemReadData;
        else          rdata_q <= ld_ext;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
  assign Error = err_q;
`else
  assign Error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Store merge: replicate store data across lanes, then per-lane select
  // between the old word and the replicated data. A word store enables every
  // lane, so the (unread) old word never reaches memory.
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][LANE_W-1:0] old_lanes, new_lanes, wr_lanes;
  logic [NUM_LANES-1:0]             lane_we;

  assign old_lanes = old_q;

  always_comb begin
    case (req_q.size)
      2'b00:   new_lanes = {4{req_q.data[7:0]}};
      2'b01:   new_lanes = {2{req_q.data[15:0]}};
      default: new_lanes = req_q.data;
    endcase
  end

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam logic [1:0] LN = 2'(n);
    assign lane_we[n] = req_q.size[1] ||
                        ((req_q.size == 2'b01) && (req_q.addr[1] == LN[1])) ||
                        ((req_q.size == 2'b00) && (req_q.addr[1:0] == LN));
    lsu_byte_lane #(.LANE_W(LANE_W)) u_lane (
      .old_b (old_lanes[n]),
      .new_b (new_lanes[n]),
      .we    (lane_we[n]),
      .out_b (wr_lanes[n])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Valid        = (state_q == RESP);
  assign RdData       = rdata_q;
  assign MemAddress   = {req_q.addr[31:2], 2'b00};
  assign MemRead      = (state_q == RD);
  assign MemWrite     = (state_q == WR);   // async reset kills an in-flight write
  assign MemWriteData = wr_lanes;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int P_RD = 1, P_WR = 2, P_RESP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req = 1'b0, IsStore = 1'b0, Unsigned = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Addr = '0, StData = '0;
  logic        Ready, Valid, Error, MemRead, MemWrite;
  logic [31:0] RdData, MemAddress, MemWriteData, MemReadData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .IsStore(IsStore), .Size(Size),
    .Unsigned(Unsigned), .Addr(Addr), .StData(StData), .Ready(Ready),
    .Valid(Valid), .RdData(RdData), .Error(Error), .MemAddress(MemAddress),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData)
  );

  // Bench memory: 64 words, aliased on address bits [7:2].
  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign MemReadData = mem[MemAddress[7:2]];
  always @(posedge clk) begin
    if (bd_we)         mem[bd_idx] <= bd_data;
    else if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
  end

  // Reference model: flat byte array, little-endian.
  logic [7:0] refb [256];

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    int unsigned b;
    b = {24'd0, a[7:2], 2'b00};
    return {refb[b+3], refb[b+2], refb[b+1], refb[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input logic [7:0] a);
    int unsigned b;
    longint v;
    if (sz == 2'd0) begin
      v = longint'(refb[a]);
      if (!un && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      b = {24'd0, a[7:1], 1'b0};
      v = longint'(refb[b]) + 256 * longint'(refb[b+1]);
      if (!un && v >= 32768) v -= 65536;
    end else begin
      b = {24'd0, a[7:2], 2'b00};
      v = longint'(refb[b]) + 256 * longint'(refb[b+1]) +
          65536 * longint'(refb[b+2]) + 16777216 * longint'(refb[b+3]);
    end
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] sd);
    int unsigned b, nb;
    if (sz == 2'd0)      begin nb = 1; b = {24'd0, a}; end
    else if (sz == 2'd1) begin nb = 2; b = {24'd0, a[7:1], 1'b0}; end
    else                 begin nb = 4; b = {24'd0, a[7:2], 2'b00}; end
    for (int i = 0; i < int'(nb); i++) refb[b+i] = 8'(sd >> (8*i));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) refb[{a[7:2], 2'b00} + 8'(i)] = 8'(w >> (8*i));
    @(negedge clk);
    bd_we = 1'b1; bd_idx = a[7:2]; bd_data = w;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // One full request: drive, then walk the expected state sequence cycle by cycle.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] sd, input string tag);
    bit mis;
    int ph[3];
    int n;
    logic [31:0] exp_rd, exp_wd, exp_ma;
    mis = TRAP && (((sz == 2'b01) && ad[0]) || (sz[1] && (ad[1:0] != 2'b00)));
    exp_rd = '0; exp_wd = '0; exp_ma = {ad[31:2], 2'b00};
    ph = '{0, 0, 0};
    if (mis) begin
      n = 1; ph[0] = P_RESP;
    end else if (!st) begin
      n = 2; ph[0] = P_RD; ph[1] = P_RESP;
      exp_rd = ref_load(sz, un, ad[7:0]);
    end else begin
      ref_store(sz, ad[7:0], sd);
      exp_wd = ref_word(ad[7:0]);
      if (sz[1]) begin n = 2; ph[0] = P_WR; ph[1] = P_RESP; end
      else       begin n = 3; ph[0] = P_RD; ph[1] = P_WR; ph[2] = P_RESP; end
    end

    @(negedge clk);
    chk({tag, "/ready_before"}, 32'(Ready), 32'd1);
    Req = 1'b1; IsStore = st; Size = sz; Unsigned = un; Addr = ad; StData = sd;
    @(posedge clk); #1;
    // Scramble inputs: the latched request must be unaffected.
    Req = 1'b0; IsStore = 1'($urandom); Size = 2'($urandom); Unsigned = 1'($urandom);
    Addr = $urandom; StData = $urandom;

    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("%s/c%0d_memread", tag, c),  32'(MemRead),  32'(ph[c] == P_RD));
      chk($sformatf("%s/c%0d_memwrite", tag, c), 32'(MemWrite), 32'(ph[c] == P_WR));
      chk($sformatf("%s/c%0d_valid", tag, c),    32'(Valid),    32'(ph[c] == P_RESP));
      chk($sformatf("%s/c%0d_ready", tag, c),    32'(Ready),    32'd0);
      if (ph[c] != P_RESP) chk($sformatf("%s/c%0d_addr", tag, c), MemAddress, exp_ma);
      if (ph[c] == P_WR)   chk($sformatf("%s/c%0d_wdata", tag, c), MemWriteData, exp_wd);
      if (ph[c] == P_RESP) begin
        chk({tag, "/rddata"}, RdData, exp_rd);
        chk({tag, "/error"},  32'(Error), 32'(mis));
      end
    end
    @(negedge clk);
    chk({tag, "/valid_after"}, 32'(Valid), 32'd0);
    chk({tag, "/ready_after"}, 32'(Ready), 32'd1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    for (int i = 0; i < 64; i++) poke(8'(i*4), $urandom);
    @(negedge clk);
    chk("rst/ready", 32'(Ready), 32'd1);
    chk("rst/valid", 32'(Valid), 32'd0);
    chk("rst/rddata", RdData, 32'd0);
    chk("rst/error", 32'(Error), 32'd0);
    chk("rst/memread", 32'(MemRead), 32'd0);
    chk("rst/memwrite", 32'(MemWrite), 32'd0);
    chk("rst/memaddr", MemAddress, 32'd0);
    chk("rst/wdata", MemWriteData, 32'd0);
    rst_n = 1'b1;

    // ---------------- directed ----------------
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "st_word");
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_word");

    poke(8'h20, 32'h11223344);
    run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, "st_byte");
    @(negedge clk);
    chk("st_byte/mem", mem[8], 32'h1122AA44);

    poke(8'h30, 32'h8000FF80);
    run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, "ld_sbyte");
    run_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, "ld_ubyte");
    run_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, "ld_shalf");
    run_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, "ld_uhalf");
    run_req(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, "ld_size3");
    run_req(1'b1, 2'b01, 1'b0, 32'h3E, 32'hCAFE1234, "st_half_hi");

    run_req(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, "ld_mis_word");
    run_req(1'b1, 2'b01, 1'b0, 32'h45, 32'h5A5A, "st_mis_half");

    // ---------------- reset during WR of a halfword store ----------------
    @(negedge clk);
    Req = 1'b1; IsStore = 1'b1; Size = 2'b01; Unsigned = 1'b0; Addr = 32'h52; StData = 32'hBEEF;
    @(posedge clk); #1;
    Req = 1'b0;
    @(negedge clk);
    chk("abort/rd", 32'(MemRead), 32'd1);
    @(negedge clk);
    chk("abort/wr", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort/memwrite_drop", 32'(MemWrite), 32'd0);
    chk("abort/ready", 32'(Ready), 32'd1);
    chk("abort/valid", 32'(Valid), 32'd0);
    @(negedge clk);
    chk("abort/valid_rst", 32'(Valid), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort/valid_post%0d", i), 32'(Valid), 32'd0);
      chk($sformatf("abort/ready_post%0d", i), 32'(Ready), 32'd1);
    end
    chk("abort/mem_unchanged", mem[20], ref_word(8'h50));
    run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, "abort/readback");

    // ---------------- Req held high across a load ----------------
    @(negedge clk);
    Req = 1'b1; IsStore = 1'b0; Size = 2'b10; Unsigned = 1'b0; Addr = 32'h10;
    @(posedge clk); #1;
    Addr = 32'h84;                       // next request, still held
    @(negedge clk);
    chk("hold/rd1", 32'(MemRead), 32'd1);
    chk("hold/addr1", MemAddress, 32'h10);
    chk("hold/ready_rd", 32'(Ready), 32'd0);
    @(negedge clk);
    chk("hold/valid1", 32'(Valid), 32'd1);
    chk("hold/rddata1", RdData, ref_word(8'h10));
    chk("hold/ready_resp", 32'(Ready), 32'd0);
    @(negedge clk);
    chk("hold/idle_ready", 32'(Ready), 32'd1);
    chk("hold/idle_memread", 32'(MemRead), 32'd0);
    chk("hold/idle_valid", 32'(Valid), 32'd0);
    @(negedge clk);
    Req = 1'b0;
    chk("hold/rd2", 32'(MemRead), 32'd1);
    chk("hold/addr2", MemAddress, 32'h84);
    @(negedge clk);
    chk("hold/valid2", 32'(Valid), 32'd1);
    chk("hold/rddata2", RdData, ref_word(8'h84));
    @(negedge clk);
    chk("hold/end_valid", 32'(Valid), 32'd0);

    // ---------------- randomized ----------------
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = {$urandom_range(0, 255) == 0 ? 24'd0 : 24'($urandom), 8'($urandom)};
      run_req(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, $sformatf("rnd%0d", i));
    end

    // ---------------- final memory image ----------------
    @(negedge clk);
    for (int i = 0; i < 64; i++)
      chk($sformatf("mem_final[%0d]", i), mem[i], ref_word(8'(i*4)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
